// File: rtl/pc_gen.sv
// Program-counter generator: warm-up sequencing, valid/ready fetch handshake, and buffered redirects.
// Optional feature: define PC_MISALIGN_TRAP_EN to send misaligned redirects to TRAP_PC and pulse misalign_o.
module pc_gen #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] INIT_PC     = '0,
  parameter logic [XLEN-1:0] TRAP_PC     = XLEN'(32'h0000_0004),
  parameter int unsigned     HOLD_CYCLES = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            stale_o,
  output logic            misalign_o
);

  typedef enum logic {S_WARMUP, S_RUN} state_t;

  localparam state_t          RST_STATE = (HOLD_CYCLES == 0) ? S_RUN : S_WARMUP;
  localparam logic [7:0]      HOLD_LIM  = 8'(HOLD_CYCLES);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

`ifdef PC_MISALIGN_TRAP_EN
  function automatic logic [XLEN-1:0] redirect_target(input logic [XLEN-1:0] raw);
    return (raw[1:0] != 2'b00) ? TRAP_PC : raw;
  endfunction
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  function automatic logic [XLEN-1:0] redirect_target(input logic [XLEN-1:0] raw);
    return raw & ALIGN_MASK;
  endfunction
`endif

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_vld_q, pend_vld_d;
  logic [XLEN-1:0] redir_tgt;
  logic            fire;

  assign pc_valid_o = (state_q == S_RUN);
  assign fire       = pc_valid_o & if_ready_i;
  assign stale_o    = fire & (redirect_i | pend_vld_q);
  assign pc_o       = pc_q;
  assign redir_tgt  = redirect_target(redirect_pc_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      pc_q       <= INIT_PC;
      pend_pc_q  <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    pend_vld_d = pend_vld_q;
    case (state_q)
      S_WARMUP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == HOLD_LIM) state_d = S_RUN;
      end
      S_RUN: begin
        if (fire) begin
          // A fresh redirect outranks an older buffered one.
          if (redirect_i)      pc_d = redir_tgt;
          else if (pend_vld_q) pc_d = pend_pc_q;
          else                 pc_d = pc_q + PC_STEP;
          pend_vld_d = 1'b0;
        end else if (redirect_i) begin
          pend_pc_d  = redir_tgt;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) misalign_q <= 1'b0;
    else          misalign_q <= pc_valid_o & redirect_i & (redirect_pc_i[1:0] != 2'b00);
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: warm-up, sequential fetch, redirects with and without stall, wrap, misalign, async reset.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;

  logic [31:0] m_pc,  h_pc,  w_pc;
  logic        m_vld, h_vld, w_vld;
  logic        m_stl, h_stl, w_stl;
  logic        m_mis, h_mis, w_mis;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_mis_pc;
  logic        exp_mis;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .INIT_PC(32'h0000_0100), .HOLD_CYCLES(1)) u_main (
    .clk_i(clk), .rst_n_i(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .if_ready_i(ready), .pc_o(m_pc), .pc_valid_o(m_vld), .stale_o(m_stl), .misalign_o(m_mis));

  pc_gen #(.XLEN(32), .INIT_PC(32'h0000_0100), .HOLD_CYCLES(3)) u_hold3 (
    .clk_i(clk), .rst_n_i(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .if_ready_i(ready), .pc_o(h_pc), .pc_valid_o(h_vld), .stale_o(h_stl), .misalign_o(h_mis));

  pc_gen #(.XLEN(32), .INIT_PC(32'hFFFF_FFF8), .HOLD_CYCLES(0)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .if_ready_i(ready), .pc_o(w_pc), .pc_valid_o(w_vld), .stale_o(w_stl), .misalign_o(w_mis));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PC_MISALIGN_TRAP_EN
    exp_mis_pc = 32'h0000_0004;
    exp_mis    = 1'b1;
`else
    exp_mis_pc = 32'h0000_0300;
    exp_mis    = 1'b0;
`endif
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ready       = 1'b1;

    #12;
    check("rst_main_pc",   m_pc,  32'h100);
    check("rst_main_vld",  32'(m_vld), 32'd0);
    check("rst_main_stl",  32'(m_stl), 32'd0);
    check("rst_main_mis",  32'(m_mis), 32'd0);
    check("rst_h3_vld",    32'(h_vld), 32'd0);
    check("rst_h3_stl",    32'(h_stl), 32'd0);
    check("rst_h3_mis",    32'(h_mis), 32'd0);
    check("rst_wrap_pc",   w_pc,  32'hFFFF_FFF8);
    check("rst_wrap_vld",  32'(w_vld), 32'd1);
    check("rst_wrap_mis",  32'(w_mis), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_main_vld",  32'(m_vld), 32'd0);
    check("rel_wrap_stl",  32'(w_stl), 32'd0);

    tick();
    check("e1_main_vld",   32'(m_vld), 32'd1);
    check("e1_main_pc",    m_pc,  32'h100);
    check("e1_wrap_pc",    w_pc,  32'hFFFF_FFFC);
    check("e1_h3_vld",     32'(h_vld), 32'd0);
    tick();
    check("e2_main_pc",    m_pc,  32'h104);
    check("e2_wrap_pc",    w_pc,  32'h0000_0000);
    check("e2_h3_vld",     32'(h_vld), 32'd0);
    tick();
    check("e3_main_pc",    m_pc,  32'h108);
    check("e3_h3_vld",     32'(h_vld), 32'd1);
    check("e3_h3_pc",      h_pc,  32'h100);

    // Redirect coinciding with fire.
    redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    check("fire_redir_stl", 32'(m_stl), 32'd1);
    tick();
    redirect = 1'b0;
    #1;
    check("redir_pc",       m_pc,  32'h200);
    check("redir_stl_clr",  32'(m_stl), 32'd0);
    tick();
    check("redir_pc_next",  m_pc,  32'h204);

    // Two redirects while stalled; the newer one wins.
    ready = 1'b0;
    #1;
    check("stall_vld",      32'(m_vld), 32'd1);
    check("stall_stl",      32'(m_stl), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    check("stall_pc_a",     m_pc,  32'h204);
    tick();
    redirect = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    #1;
    check("stall_pc_b",     m_pc,  32'h204);
    check("stall_stl_b",    32'(m_stl), 32'd0);
    ready = 1'b1;
    #1;
    check("pend_fire_stl",  32'(m_stl), 32'd1);
    tick();
    check("pend_pc",        m_pc,  32'h400);
    check("pend_clr_stl",   32'(m_stl), 32'd0);
    tick();
    check("pend_pc_next",   m_pc,  32'h404);

    // Misaligned redirect.
    redirect = 1'b1; redirect_pc = 32'h302;
    tick();
    redirect = 1'b0;
    #1;
    check("mis_pc",         m_pc,  exp_mis_pc);
    check("mis_pulse",      32'(m_mis), 32'(exp_mis));
    tick();
    check("mis_pulse_end",  32'(m_mis), 32'd0);
    check("mis_pc_next",    m_pc,  exp_mis_pc + 32'd4);

    // Async reset while stalled with a pending redirect.
    ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h500;
    tick();
    redirect = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc",        m_pc,  32'h100);
    check("arst_vld",       32'(m_vld), 32'd0);
    check("arst_stl",       32'(m_stl), 32'd0);
    check("arst_wrap_pc",   w_pc,  32'hFFFF_FFF8);
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    #1;
    check("arst_rel_stl",   32'(m_stl), 32'd0);
    tick();
    check("arst_e1_vld",    32'(m_vld), 32'd1);
    check("arst_e1_pc",     m_pc,  32'h100);
    check("arst_e1_stl",    32'(m_stl), 32'd0);
    tick();
    check("arst_e2_pc",     m_pc,  32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
